dct2_odd_pipe: RTL

DCT2_ODD_PIPE -- requirements
Module: dct2_odd_pipe

---
 rtl/dct2_odd_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dct2_odd_pipe.sv
// dct2_odd_pipe: 3-stage DCT-II even/odd butterfly with shift-add odd-part matrix for 4..32 points
module dct2_odd_pipe #(
    parameter int IN_W = 16,
    parameter int E_W  = IN_W + 1,
    parameter int O_W  = IN_W + 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_size,
    input  logic [31:0][IN_W-1:0] in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_size,
    output logic [15:0][E_W-1:0]  out_e,
    output logic [15:0][O_W-1:0]  out_o
);

    // |cos(t*pi/64)| scaled to the integer VVC basis, index t = 0..32
    localparam logic [32:0][6:0] MAG = {
        7'd0,  7'd4,  7'd9,  7'd13, 7'd18, 7'd22, 7'd25, 7'd31,
        7'd36, 7'd38, 7'd43, 7'd46, 7'd50, 7'd54, 7'd57, 7'd61,
        7'd64, 7'd67, 7'd70, 7'd73, 7'd75, 7'd78, 7'd80, 7'd82,
        7'd83, 7'd85, 7'd87, 7'd88, 7'd89, 7'd90, 7'd90, 7'd90,
        7'd64
    };

    // C_N[2k+1][n] for N = 4 << sz; zero outside the N/2 x N/2 odd block
    function automatic int coef(input int sz, input int k, input int n);
        int t;
        if (k >= (2 << sz) || n >= (2 << sz)) return 0;
        t = ((2 * k + 1) * (2 * n + 1) * (8 >> sz)) % 128;
        if (t > 64) t = 128 - t;
        return t < 32 ? int'(MAG[6'(t)]) : (t == 32 ? 0 : -int'(MAG[6'(64 - t)]));
    endfunction

    function automatic logic signed [O_W-1:0] smul(input logic signed [O_W-1:0] x,
                                                   input logic signed [7:0] c);
        logic signed [O_W-1:0] acc;
        logic [7:0] m;
        acc = '0;
        m = c[7] ? -c : c;
        for (int b = 0; b < 8; b++) if (m[b]) acc = acc + (x <<< b);
        return c[7] ? -acc : acc;
    endfunction

    function automatic logic signed [IN_W:0] sx(input logic [IN_W-1:0] v);
        return $signed({v[IN_W-1], v});
    endfunction

    logic v1, v2, v3, ld2, ld3;
    logic [1:0] sz1, sz2;
    logic [15:0][E_W-1:0] e_c, e1, e2;
    logic [15:0][IN_W:0] o_c, o1;
    logic [15:0][O_W-1:0] ps_a, ps_b, p2a, p2b;
    logic signed [7:0] cm [16][16];

    assign ld3 = !v3 | out_ready;
    assign ld2 = !v2 | ld3;
    assign in_ready = !v1 | ld2;
    assign out_valid = v3;

    for (genvar i = 0; i < 16; i++) begin : g_bf
        logic [4:0] j;
        logic signed [IN_W:0] a, b;
        assign j = 5'((4 << in_size) - 1 - i);
        assign a = sx(in_x[i]);
        assign b = sx(in_x[j]);
        assign e_c[i] = i < (2 << in_size) ? E_W'(a + b) : '0;
        assign o_c[i] = i < (2 << in_size) ? a - b : '0;
    end

    for (genvar k = 0; k < 16; k++) begin : g_row
        for (genvar n = 0; n < 16; n++) begin : g_col
            assign cm[k][n] = 8'(sz1 == 2'd0 ? coef(0, k, n) :
                                 sz1 == 2'd1 ? coef(1, k, n) :
                                 sz1 == 2'd2 ? coef(2, k, n) : coef(3, k, n));
        end
    end

    // two 8-term shift-add partial sums per odd output
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            ps_a[k] = '0;
            ps_b[k] = '0;
            for (int n = 0; n < 8; n++) begin
                ps_a[k] = ps_a[k] + smul(O_W'($signed(o1[n])), cm[k][n]);
                ps_b[k] = ps_b[k] + smul(O_W'($signed(o1[n + 8])), cm[k][n + 8]);
            end
        end
    end

    // S1: butterfly decomposition and size of the accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            sz1 <= '0;
            e1  <= '0;
            o1  <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                sz1 <= in_size;
                e1  <= e_c;
                o1  <= o_c;
            end
        end
    end

    // S2: partial sums, even terms and size follow the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            sz2 <= '0;
            e2  <= '0;
            p2a <= '0;
            p2b <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                sz2 <= sz1;
                e2  <= e1;
                p2a <= ps_a;
                p2b <= ps_b;
            end
        end
    end

    // S3: final odd sums form the held output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3       <= 1'b0;
            out_size <= '0;
            out_e    <= '0;
            out_o    <= '0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                out_size <= sz2;
                out_e    <= e2;
                for (int k = 0; k < 16; k++) out_o[k] <= p2a[k] + p2b[k];
            end
        end
    end

endmodule
